// File: rtl/usbdev_pkt_fifos.sv
// Buffer-ID queueing stage next to the USB interface core.
// Two independent FWFT FIFOs share one structure: the AV FIFO holds free
// packet-buffer IDs and the RX FIFO holds received-packet descriptors.
//
// Handshake: a push is taken on a clock edge when wvalid & wready, and a pop
// when rready & rvalid. wready, rvalid and depth come only from registered
// pointers, so no input affects them combinationally. rdata shows the head
// entry while rvalid is high and reads as zero otherwise.

module usbdev_pkt_fifo_core #(
   parameter int DEPTH = 4,
   parameter int WIDTH = 4
) (
   input  logic                         i_clk,
   input  logic                         i_rst,
   input  logic                         i_flush,
   input  logic                         i_wvalid,
   output logic                         o_wready,
   input  logic [WIDTH-1:0]             i_wdata,
   output logic                         o_rvalid,
   input  logic                         i_rready,
   output logic [WIDTH-1:0]             o_rdata,
   output logic [$clog2(DEPTH+1)-1:0]   o_depth
);

   localparam int IW = $clog2(DEPTH);
   localparam int PW = IW + 1;
   localparam int DW = $clog2(DEPTH+1);

   // MSB of each pointer is the wrap bit; the lower bits index storage
   logic [PW-1:0]    r_wptr;
   logic [PW-1:0]    r_rptr;
   logic [WIDTH-1:0] r_mem [DEPTH];

   logic             w_empty;
   logic             w_full;
   logic             w_push;
   logic             w_pop;
   logic [PW-1:0]    w_level;

   assign w_empty  = (r_wptr == r_rptr);
   assign w_full   = (r_wptr[IW-1:0] == r_rptr[IW-1:0]) &&
                     (r_wptr[IW] != r_rptr[IW]);
   // A push is refused while full even if a pop happens in the same cycle
   assign w_push   = i_wvalid & ~w_full;
   assign w_pop    = i_rready & ~w_empty;
   assign w_level  = r_wptr - r_rptr;

   assign o_wready = ~w_full;
   assign o_rvalid = ~w_empty;
   assign o_depth  = DW'(w_level);
   assign o_rdata  = w_empty ? '0 : r_mem[r_rptr[IW-1:0]];

   // Pointer update; flush wins over any same-cycle push or pop
   always_ff @(posedge i_clk or posedge i_rst) begin
      if (i_rst) begin
         r_wptr <= '0;
         r_rptr <= '0;
      end else if (i_flush) begin
         r_wptr <= '0;
         r_rptr <= '0;
      end else begin
         if (w_push) r_wptr <= r_wptr + PW'(1);
         if (w_pop)  r_rptr <= r_rptr + PW'(1);
      end
   end

   // Storage write; contents are not reset, only the pointers are.
   // The head slot is never written while occupied, so rdata stays stable.
   always_ff @(posedge i_clk) begin
      if (w_push && !i_flush) r_mem[r_wptr[IW-1:0]] <= i_wdata;
   end

endmodule

module usbdev_pkt_fifos #(
   parameter int AVDepth = 4,
   parameter int AVWidth = 4,
   parameter int RXDepth = 4,
   parameter int RXWidth = 16
) (
   input  logic                           clk_48mhz_i,
   input  logic                           rst_i,
   input  logic                           av_wvalid_i,
   output logic                           av_wready_o,
   input  logic [AVWidth-1:0]             av_wdata_i,
   output logic                           av_rvalid_o,
   input  logic                           av_rready_i,
   output logic [AVWidth-1:0]             av_rdata_o,
   input  logic                           rx_wvalid_i,
   output logic                           rx_wready_o,
   input  logic [RXWidth-1:0]             rx_wdata_i,
   output logic                           rx_rvalid_o,
   input  logic                           rx_rready_i,
   output logic [RXWidth-1:0]             rx_rdata_o,
   input  logic                           av_flush_i,
   input  logic                           rx_flush_i,
   output logic [$clog2(AVDepth+1)-1:0]   av_depth_o,
   output logic [$clog2(RXDepth+1)-1:0]   rx_depth_o,
   output logic                           av_overflow_o,
   output logic                           rx_underrun_o
);

   logic r_av_overflow;
   logic r_rx_underrun;

   usbdev_pkt_fifo_core #(
      .DEPTH (AVDepth),
      .WIDTH (AVWidth)
   ) u_av_fifo (
      .i_clk    (clk_48mhz_i),
      .i_rst    (rst_i),
      .i_flush  (av_flush_i),
      .i_wvalid (av_wvalid_i),
      .o_wready (av_wready_o),
      .i_wdata  (av_wdata_i),
      .o_rvalid (av_rvalid_o),
      .i_rready (av_rready_i),
      .o_rdata  (av_rdata_o),
      .o_depth  (av_depth_o)
   );

   usbdev_pkt_fifo_core #(
      .DEPTH (RXDepth),
      .WIDTH (RXWidth)
   ) u_rx_fifo (
      .i_clk    (clk_48mhz_i),
      .i_rst    (rst_i),
      .i_flush  (rx_flush_i),
      .i_wvalid (rx_wvalid_i),
      .o_wready (rx_wready_o),
      .i_wdata  (rx_wdata_i),
      .o_rvalid (rx_rvalid_o),
      .i_rready (rx_rready_i),
      .o_rdata  (rx_rdata_o),
      .o_depth  (rx_depth_o)
   );

   // One-cycle error pulses; a flush in the same cycle suppresses them
   always_ff @(posedge clk_48mhz_i or posedge rst_i) begin
      if (rst_i) begin
         r_av_overflow <= 1'b0;
         r_rx_underrun <= 1'b0;
      end else begin
         r_av_overflow <= av_wvalid_i & ~av_wready_o & ~av_flush_i;
         r_rx_underrun <= rx_rready_i & ~rx_rvalid_o & ~rx_flush_i;
      end
   end

   assign av_overflow_o = r_av_overflow;
   assign rx_underrun_o = r_rx_underrun;

endmodule

// File: tb/tb_usbdev_pkt_fifos.sv
// Self-checking bench for usbdev_pkt_fifos against a queue-based model.
module tb_usbdev_pkt_fifos;

   localparam int AVD = 4;
   localparam int AVW = 4;
   localparam int RXD = 4;
   localparam int RXW = 16;

   logic           clk;
   logic           rst;
   logic           av_wvalid;
   logic           av_wready;
   logic [AVW-1:0] av_wdata;
   logic           av_rvalid;
   logic           av_rready;
   logic [AVW-1:0] av_rdata;
   logic           rx_wvalid;
   logic           rx_wready;
   logic [RXW-1:0] rx_wdata;
   logic           rx_rvalid;
   logic           rx_rready;
   logic [RXW-1:0] rx_rdata;
   logic           av_flush;
   logic           rx_flush;
   logic [2:0]     av_depth;
   logic [2:0]     rx_depth;
   logic           av_overflow;
   logic           rx_underrun;

   int n_checks;
   int n_errors;

   // reference model: plain queues of accepted entries plus expected pulses
   logic [AVW-1:0] av_q[$];
   logic [RXW-1:0] rx_q[$];
   logic           exp_ovf;
   logic           exp_unr;

   usbdev_pkt_fifos #(
      .AVDepth (AVD), .AVWidth (AVW), .RXDepth (RXD), .RXWidth (RXW)
   ) dut (
      .clk_48mhz_i   (clk),
      .rst_i         (rst),
      .av_wvalid_i   (av_wvalid),
      .av_wready_o   (av_wready),
      .av_wdata_i    (av_wdata),
      .av_rvalid_o   (av_rvalid),
      .av_rready_i   (av_rready),
      .av_rdata_o    (av_rdata),
      .rx_wvalid_i   (rx_wvalid),
      .rx_wready_o   (rx_wready),
      .rx_wdata_i    (rx_wdata),
      .rx_rvalid_o   (rx_rvalid),
      .rx_rready_i   (rx_rready),
      .rx_rdata_o    (rx_rdata),
      .av_flush_i    (av_flush),
      .rx_flush_i    (rx_flush),
      .av_depth_o    (av_depth),
      .rx_depth_o    (rx_depth),
      .av_overflow_o (av_overflow),
      .rx_underrun_o (rx_underrun)
   );

   // clock
   initial clk = 1'b0;
   always #10 clk = ~clk;

   task automatic check_eq(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_checks++;
      if (obs !== exp) begin
         n_errors++;
         $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", tag, obs, exp, $time);
      end
   endtask

   task automatic idle_inputs();
      av_wvalid = 1'b0; av_wdata = '0; av_rready = 1'b0; av_flush = 1'b0;
      rx_wvalid = 1'b0; rx_wdata = '0; rx_rready = 1'b0; rx_flush = 1'b0;
   endtask

   task automatic model_clear();
      av_q.delete();
      rx_q.delete();
      exp_ovf = 1'b0;
      exp_unr = 1'b0;
   endtask

   task automatic check_outputs();
      check_eq("av_rvalid", av_rvalid, av_q.size() != 0);
      check_eq("av_wready", av_wready, av_q.size() != AVD);
      check_eq("av_depth",  av_depth,  av_q.size());
      check_eq("av_rdata",  av_rdata,  av_q.size() != 0 ? av_q[0] : '0);
      check_eq("rx_rvalid", rx_rvalid, rx_q.size() != 0);
      check_eq("rx_wready", rx_wready, rx_q.size() != RXD);
      check_eq("rx_depth",  rx_depth,  rx_q.size());
      check_eq("rx_rdata",  rx_rdata,  rx_q.size() != 0 ? rx_q[0] : '0);
      check_eq("av_overflow", av_overflow, exp_ovf);
      check_eq("rx_underrun", rx_underrun, exp_unr);
   endtask

   // Called 1ns after a rising edge with inputs already driven: check the
   // current outputs, advance the model by one edge, and move to the next one.
   task automatic cycle();
      bit av_full, av_empty, rx_full, rx_empty, nxt_ovf, nxt_unr;
      check_outputs();
      av_full  = (av_q.size() == AVD);
      av_empty = (av_q.size() == 0);
      rx_full  = (rx_q.size() == RXD);
      rx_empty = (rx_q.size() == 0);
      nxt_ovf  = av_wvalid && av_full && !av_flush;
      nxt_unr  = rx_rready && rx_empty && !rx_flush;
      if (av_flush) av_q.delete();
      else begin
         if (av_rready && !av_empty) void'(av_q.pop_front());
         if (av_wvalid && !av_full) av_q.push_back(av_wdata);
      end
      if (rx_flush) rx_q.delete();
      else begin
         if (rx_rready && !rx_empty) void'(rx_q.pop_front());
         if (rx_wvalid && !rx_full) rx_q.push_back(rx_wdata);
      end
      @(posedge clk);
      #1;
      exp_ovf = nxt_ovf;
      exp_unr = nxt_unr;
   endtask

   task automatic av_push(input logic [AVW-1:0] d);
      idle_inputs(); av_wvalid = 1'b1; av_wdata = d; cycle();
   endtask

   task automatic av_pop();
      idle_inputs(); av_rready = 1'b1; cycle();
   endtask

   initial begin
      n_checks = 0;
      n_errors = 0;
      idle_inputs();
      model_clear();
      rst = 1'b1;
      #25;
      check_outputs();          // reset state while reset held
      @(negedge clk);
      rst = 1'b0;
      @(posedge clk);
      #1;

      // 1: fill AV with IDs 1..4
      for (int i = 1; i <= 4; i++) av_push(AVW'(i));
      // 2: push while full, then drain in order
      av_push(4'd9);
      idle_inputs(); cycle();   // overflow pulse seen here, then cleared
      for (int i = 0; i < 4; i++) av_pop();
      idle_inputs(); cycle();

      // 3: RX alternating push/pop across the pointer wrap
      for (int n = 0; n < 7; n++) begin
         idle_inputs(); rx_wvalid = 1'b1; rx_wdata = RXW'(16'h1000 + n); cycle();
         check_eq("rx_depth_le1", rx_depth <= 3'd1, 1);
         idle_inputs(); rx_rready = 1'b1; cycle();
      end

      // 4: push with rready on empty FIFOs
      idle_inputs();
      av_wvalid = 1'b1; av_wdata = 4'hA; av_rready = 1'b1;
      rx_wvalid = 1'b1; rx_wdata = 16'hBEEF; rx_rready = 1'b1;
      cycle();
      idle_inputs(); cycle();

      // 5: RX to depth 3, then flush with push and pop
      idle_inputs(); rx_wvalid = 1'b1; rx_wdata = 16'h2222; cycle();
      idle_inputs(); rx_wvalid = 1'b1; rx_wdata = 16'h3333; cycle();
      idle_inputs();
      rx_flush = 1'b1; rx_wvalid = 1'b1; rx_wdata = 16'h4444; rx_rready = 1'b1;
      cycle();
      idle_inputs(); cycle();

      // 6: AV at depth 2 (one entry from test 4 plus one), async reset mid-cycle
      av_push(4'h5);
      idle_inputs();
      check_outputs();
      @(negedge clk);
      rst = 1'b1;
      #1;
      model_clear();
      check_outputs();          // reset state without waiting for an edge
      @(negedge clk);
      rst = 1'b0;
      @(posedge clk);
      #1;
      av_push(4'h7);
      idle_inputs(); cycle();

      // random traffic against the model
      for (int c = 0; c < 600; c++) begin
         av_wvalid = 1'($urandom_range(0, 1));
         av_wdata  = AVW'($urandom);
         av_rready = 1'($urandom_range(0, 1));
         av_flush  = ($urandom_range(0, 29) == 0);
         rx_wvalid = 1'($urandom_range(0, 1));
         rx_wdata  = RXW'($urandom);
         rx_rready = 1'($urandom_range(0, 1));
         rx_flush  = ($urandom_range(0, 29) == 0);
         cycle();
      end
      idle_inputs();
      cycle();
      check_outputs();

      $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
      $finish;
   end

endmodule
